axi_rd_xbar: RTL



---
 rtl/axi_rd_xbar_pkg.sv | 27 ++
 rtl/axi_rd_xbar_if.sv | 39 +++
 rtl/axi_rd_xbar_rr_arbiter.sv | 30 +++
 rtl/axi_rd_xbar.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/axi_rd_xbar_pkg.sv
// axi_xbar_pkg: shared types and constants for the AXI4 read crossbar.
//   state_e            - crossbar FSM states
//   RESP_OKAY/DECERR   - AXI read response codes
//   DEF_BASE/DEF_MASK  - default six-slave address map (ROM, IM, DM, sensor, WDT, DRAM)
//   idx_w()            - index width helper that never returns zero
package axi_xbar_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Index 0 is the rightmost entry: ROM, IM, DM, sensor, WDT, DRAM.
    localparam logic [5:0][31:0] DEF_BASE = {
        32'h2000_0000, 32'h1001_0000, 32'h1000_0000,
        32'h0002_0000, 32'h0001_0000, 32'h0000_0000
    };
    localparam logic [5:0][31:0] DEF_MASK = {
        32'hFFE0_0000, 32'hFFFF_FC00, 32'hFFFF_FC00,
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_E000
    };

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rd_xbar_if.sv
// axi_rd_xbar_if: N parallel AXI4 read channels (AR + R) as packed arrays.
//   master modport - issues AR, accepts R (used by the crossbar towards slaves)
//   slave  modport - accepts AR, returns R (used by the crossbar towards masters)
// Parameters: N channels, ID_W id width, ADDR_W, DATA_W, LEN_W.
interface axi_rd_xbar_if #(
    parameter int N      = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [N-1:0][ID_W-1:0]   arid;
    logic [N-1:0][ADDR_W-1:0] araddr;
    logic [N-1:0][LEN_W-1:0]  arlen;
    logic [N-1:0][2:0]        arsize;
    logic [N-1:0][1:0]        arburst;
    logic [N-1:0]             arvalid;
    logic [N-1:0]             arready;
    logic [N-1:0][ID_W-1:0]   rid;
    logic [N-1:0][DATA_W-1:0] rdata;
    logic [N-1:0][1:0]        rresp;
    logic [N-1:0]             rlast;
    logic [N-1:0]             rvalid;
    logic [N-1:0]             rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_xbar_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req - request vector, ptr - highest-priority index this round
//   gnt - one-hot grant (zero when no request), idx - binary grant index
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        logic found;
        int   k;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        // Scan cyclically starting at ptr; first requester wins.
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/axi_rd_xbar.sv
// axi_rd_xbar: NUM_M x NUM_S AXI4 read crossbar, one outstanding burst.
//   ACLK, ARESETn - clock, asynchronous active-low reset
//   m             - master-facing read channels (ID_W ids)
//   s             - slave-facing read channels (ID_W+$clog2(NUM_M) ids,
//                   master index prepended)
// Round-robin AR arbitration, lowest-index base/mask decode. Payload is
// passed through, never buffered.
// Build option AXI_XBAR_DECERR_EN: unmapped reads are answered locally with
// DECERR beats; without it a miss is routed to slave NUM_S-1.
module axi_rd_xbar
    import axi_xbar_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 6,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter logic [NUM_S-1:0][ADDR_W-1:0] S_BASE = DEF_BASE,
    parameter logic [NUM_S-1:0][ADDR_W-1:0] S_MASK = DEF_MASK
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    axi_rd_xbar_if.slave  m,
    axi_rd_xbar_if.master s
);
    localparam int MI_W  = idx_w(NUM_M);
    localparam int TGT_W = idx_w(NUM_S);

    state_e             state, nxt;
    logic [MI_W-1:0]    gnt, ptr, arb_idx, nxt_ptr;
    logic [NUM_M-1:0]   arb_onehot;
    logic [TGT_W-1:0]   tgt, dec_idx;
    logic               dec_hit, r_done;
`ifdef AXI_XBAR_DECERR_EN
    logic               err_q;
    logic [LEN_W-1:0]   cnt;
    logic [ID_W-1:0]    arid_q;
`endif

    rr_arbiter #(.N(NUM_M), .IDX_W(MI_W)) u_arb (
        .req (m.arvalid),
        .ptr (ptr),
        .gnt (arb_onehot),
        .idx (arb_idx)
    );

    // Downward scan so the lowest-index hit is what remains.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if ((m.araddr[arb_idx] & S_MASK[i]) == S_BASE[i]) begin
                dec_hit = 1'b1;
                dec_idx = TGT_W'(i);
            end
        end
    end

    assign r_done  = s.rvalid[tgt] & m.rready[gnt] & s.rlast[tgt];
    assign nxt_ptr = (gnt == MI_W'(NUM_M - 1)) ? '0 : gnt + MI_W'(1);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= ST_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (|arb_onehot) nxt = ST_ADDR;
            ST_ADDR: begin
`ifdef AXI_XBAR_DECERR_EN
                if (err_q) nxt = ST_ERR;
                else
`endif
                if (m.arvalid[gnt] && s.arready[tgt]) nxt = ST_DATA;
            end
            ST_DATA: if (r_done) nxt = ST_IDLE;
`ifdef AXI_XBAR_DECERR_EN
            ST_ERR:  if (m.rready[gnt] && cnt == '0) nxt = ST_IDLE;
`endif
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            gnt    <= '0;
            tgt    <= '0;
            ptr    <= '0;
`ifdef AXI_XBAR_DECERR_EN
            err_q  <= 1'b0;
            cnt    <= '0;
            arid_q <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (|arb_onehot) begin
                    gnt <= arb_idx;
`ifdef AXI_XBAR_DECERR_EN
                    tgt   <= dec_idx;
                    err_q <= ~dec_hit;
`else
                    tgt <= dec_hit ? dec_idx : TGT_W'(NUM_S - 1);
`endif
                end
`ifdef AXI_XBAR_DECERR_EN
                ST_ADDR: if (err_q) begin
                    cnt    <= m.arlen[gnt];
                    arid_q <= m.arid[gnt];
                end
                ST_ERR: if (m.rready[gnt]) begin
                    if (cnt == '0) ptr <= nxt_ptr;
                    else           cnt <= cnt - LEN_W'(1);
                end
`endif
                ST_DATA: if (r_done) ptr <= nxt_ptr;
                default: ;
            endcase
        end
    end

    // Everything defaults to 0; only the granted master / decoded slave pair
    // is connected, and only for the channel the current state owns.
    always_comb begin
        m.arready = '0;
        m.rid     = '0;
        m.rdata   = '0;
        m.rresp   = '0;
        m.rlast   = '0;
        m.rvalid  = '0;
        s.arid    = '0;
        s.araddr  = '0;
        s.arlen   = '0;
        s.arsize  = '0;
        s.arburst = '0;
        s.arvalid = '0;
        s.rready  = '0;
        case (state)
            ST_ADDR: begin
`ifdef AXI_XBAR_DECERR_EN
                if (err_q) m.arready[gnt] = 1'b1;
                else
`endif
                begin
                    s.arvalid[tgt] = m.arvalid[gnt];
                    s.arid[tgt]    = {gnt, m.arid[gnt]};
                    s.araddr[tgt]  = m.araddr[gnt];
                    s.arlen[tgt]   = m.arlen[gnt];
                    s.arsize[tgt]  = m.arsize[gnt];
                    s.arburst[tgt] = m.arburst[gnt];
                    m.arready[gnt] = s.arready[tgt];
                end
            end
            ST_DATA: begin
                m.rvalid[gnt] = s.rvalid[tgt];
                m.rid[gnt]    = s.rid[tgt][ID_W-1:0];
                m.rdata[gnt]  = s.rdata[tgt];
                m.rresp[gnt]  = s.rresp[tgt];
                m.rlast[gnt]  = s.rlast[tgt];
                s.rready[tgt] = m.rready[gnt];
            end
`ifdef AXI_XBAR_DECERR_EN
            ST_ERR: begin
                m.rvalid[gnt] = 1'b1;
                m.rid[gnt]    = arid_q;
                m.rresp[gnt]  = RESP_DECERR;
                m.rlast[gnt]  = (cnt == '0);
            end
`endif
            default: ;
        endcase
    end
endmodule
